// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: round-robin front end that feeds words from two
// requesters, MSB first, into one serial Moore pattern detector and returns
// one saturating match count per word.
// Build option: define SEQ_DET_OVERLAP_EN to let consecutive matches share
// bits; the default build restarts the search after every match.
module seq_det_scheduler #(
  parameter int unsigned       WORD_W      = 16,
  parameter int unsigned       PAT_W       = 6,
  parameter logic [PAT_W-1:0]  PAT_DEFAULT = 6'b110101,
  parameter int unsigned       CNT_W       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              pat_load,
  input  logic [PAT_W-1:0]  pat_in,
  output logic              busy,
  output logic              x_out,
  output logic              y_det,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [CNT_W-1:0]  resp_count
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int HL_W  = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                rr_last_q;
  logic [PAT_W-1:0]    pat_q;
  logic [WORD_W-1:0]   word_q;
  logic [BIT_W-1:0]    bit_q;
  logic [PAT_W-2:0]    hist_q, hist_d;
  logic [HL_W-1:0]     hlen_q, hlen_d;
  logic [CNT_W-1:0]    count_q;
  logic                id_q;
  logic                y_q;

  logic                grant;
  logic                accept;
  logic                last_bit;
  logic [PAT_W-1:0]    hist_shift;
  logic [HL_W-1:0]     hlen_inc;
  logic                match;

  // Count increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~rr_last_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  // Detector step: append the presented bit and test the newest PAT_W bits
  // collected since the word start (or since the previous match).
  always_comb begin
    hist_shift = {hist_q, word_q[WORD_W-1]};
    hlen_inc   = (hlen_q == HL_W'(PAT_W)) ? hlen_q : hlen_q + 1'b1;
    match      = (hlen_inc == HL_W'(PAT_W)) && (hist_shift == pat_q);
`ifdef SEQ_DET_OVERLAP_EN
    // History survives a match, so trailing bits can start the next one.
    hist_d     = hist_shift[PAT_W-2:0];
    hlen_d     = hlen_inc;
`else
    // A match consumes its bits; the search restarts from nothing.
    hist_d     = match ? '0 : hist_shift[PAT_W-2:0];
    hlen_d     = match ? '0 : hlen_inc;
`endif
  end

  assign last_bit = (bit_q == BIT_W'(WORD_W - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all externally visible strobes.
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    busy       = 1'b0;
    x_out      = 1'b0;
    resp_valid = 1'b0;
    resp_id    = 1'b0;
    resp_count = '0;
    case (state_q)
      S_IDLE: begin
        req0_ready = req0_valid && !grant;
        req1_ready = req1_valid && grant;
        accept     = req0_valid || req1_valid;
        if (accept) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy  = 1'b1;
        x_out = word_q[WORD_W-1];
        if (last_bit) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        resp_id    = id_q;
        resp_count = count_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign y_det = y_q;

  // Word capture, bit shifting, detector history, match count and pattern register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q     <= PAT_DEFAULT;
      rr_last_q <= 1'b1;
      word_q    <= '0;
      bit_q     <= '0;
      hist_q    <= '0;
      hlen_q    <= '0;
      count_q   <= '0;
      id_q      <= 1'b0;
      y_q       <= 1'b0;
    end else begin
      y_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pat_load) begin
            pat_q <= pat_in;
          end
          if (accept) begin
            word_q    <= grant ? req1_data : req0_data;
            id_q      <= grant;
            rr_last_q <= grant;
            bit_q     <= '0;
            hist_q    <= '0;
            hlen_q    <= '0;
            count_q   <= '0;
          end
        end
        S_SHIFT: begin
          word_q <= word_q << 1;
          bit_q  <= bit_q + 1'b1;
          hist_q <= hist_d;
          hlen_q <= hlen_d;
          if (match) begin
            count_q <= sat_inc(count_q);
            y_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a bit-string reference model.
module tb_seq_det_scheduler;

  localparam int W  = 16;
  localparam int PW = 6;
  localparam int CW = 5;
  localparam logic [PW-1:0] PDEF = 6'b110101;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0]  req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          pat_load = 1'b0;
  logic [PW-1:0] pat_in = '0;
  logic          busy, x_out, y_det, resp_valid, resp_id;
  logic [CW-1:0] resp_count;

  always #5 clk = ~clk;

  seq_det_scheduler #(.WORD_W(W), .PAT_W(PW), .PAT_DEFAULT(PDEF), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .pat_load(pat_load), .pat_in(pat_in),
    .busy(busy), .x_out(x_out), .y_det(y_det),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_count(resp_count)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: job in progress described by its cycle index 1..W+1.
  bit            m_active;
  int            m_jc;
  logic [W-1:0]  m_word;
  bit            m_id;
  logic [PW-1:0] m_pat;
  bit            m_rr_last;
  bit            m_hits[W+1];
  int            m_cnt;
  bit            acc0, acc1;

  // Observations of the DUT.
  int n_resp = 0;
  int last_cnt, last_resp_cyc;
  int acc_cyc[$];
  int y_cyc[$];
  int resp_ids[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_active  = 0;
    m_jc      = 0;
    m_pat     = PDEF;
    m_rr_last = 1;
    m_cnt     = 0;
  endfunction

  // Scan the word as a bit string: bit b (1-based, MSB first) completes a
  // match when the PW bits ending at b all lie after the restart point and
  // equal the pattern.
  function automatic void model_job(input logic [W-1:0] w, input logic [PW-1:0] p);
    int start;
    bit ok;
    start = 1;
    m_cnt = 0;
    for (int b = 0; b <= W; b++) m_hits[b] = 0;
    for (int b = 1; b <= W; b++) begin
      if (b - start + 1 >= PW) begin
        ok = 1;
        for (int k = 0; k < PW; k++)
          if (w[W - (b - PW + 1 + k)] !== p[PW - 1 - k]) ok = 0;
        if (ok) begin
          m_hits[b] = 1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
`ifdef SEQ_DET_OVERLAP_EN
          start = start;
`else
          start = b + 1;
`endif
        end
      end
    end
  endfunction

  // One clock: compare outputs, record observations, advance model, move to next negedge.
  task automatic cycle();
    logic idle, r0, r1, ex, ey, erv;
    #1;
    idle = !m_active;
    r0   = idle && req0_valid && (!req1_valid || m_rr_last);
    r1   = idle && req1_valid && (!req0_valid || !m_rr_last);
    erv  = m_active && (m_jc == W + 1);
    ex   = (m_active && m_jc <= W) ? m_word[W - m_jc] : 1'b0;
    ey   = (m_active && m_jc >= 2) ? m_hits[m_jc - 1] : 1'b0;
    check_eq("req0_ready", req0_ready, r0);
    check_eq("req1_ready", req1_ready, r1);
    check_eq("busy", busy, m_active);
    check_eq("x_out", x_out, ex);
    check_eq("y_det", y_det, ey);
    check_eq("resp_valid", resp_valid, erv);
    check_eq("resp_id", resp_id, erv ? m_id : 1'b0);
    check_eq("resp_count", resp_count, erv ? m_cnt : 0);
    if (resp_valid) begin
      n_resp++;
      last_cnt = resp_count;
      last_resp_cyc = cyc;
      resp_ids.push_back(resp_id);
    end
    if (y_det) y_cyc.push_back(cyc);
    if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) acc_cyc.push_back(cyc);
    acc0 = 0;
    acc1 = 0;
    if (m_active) begin
      m_jc++;
      if (m_jc > W + 1) m_active = 0;
    end else begin
      if (pat_load) m_pat = pat_in;
      if (r0 || r1) begin
        m_word    = r1 ? req1_data : req0_data;
        m_id      = r1;
        m_rr_last = r1;
        model_job(m_word, m_pat);
        m_active  = 1;
        m_jc      = 1;
        acc0      = r0;
        acc1      = r1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    req0_valid = 0;
    req1_valid = 0;
    pat_load   = 0;
    reset      = 1;
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_x_out", x_out, 0);
    check_eq("rst_y_det", y_det, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_count", resp_count, 0);
    check_eq("rst_ready", {req0_ready, req1_ready}, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    reset = 0;
  endtask

  task automatic wait_resp();
    int n0;
    int t;
    n0 = n_resp;
    t  = 0;
    while (n_resp == n0 && t < 40) begin
      cycle();
      t++;
    end
    check_eq("resp_seen", (n_resp != n0), 1);
  endtask

  task automatic clear_obs();
    acc_cyc.delete();
    y_cyc.delete();
    resp_ids.delete();
  endtask

  task automatic serve(input bit id, input logic [W-1:0] w);
    clear_obs();
    if (id) begin req1_valid = 1; req1_data = w; end
    else    begin req0_valid = 1; req0_data = w; end
    for (int t = 0; t < 10 && (req0_valid || req1_valid); t++) begin
      cycle();
      pat_load = 0;
      if (acc0) req0_valid = 0;
      if (acc1) req1_valid = 0;
    end
    wait_resp();
  endtask

  function automatic int first_acc();
    return (acc_cyc.size() > 0) ? acc_cyc[0] : -1000;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    int pos;
    w = W'($urandom);
    if ($urandom_range(1) == 1) begin
      pos = int'($urandom_range(W - PW));
      w[pos +: PW] = m_pat;
    end
    return w;
  endfunction

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // T1: single word, one match at bit 6, latency 17
    serve(0, 16'hD400);
    check_eq("t1_id", resp_ids.size() > 0 ? resp_ids[0] : 9, 0);
    check_eq("t1_count", last_cnt, 1);
    check_eq("t1_latency", last_resp_cyc - first_acc(), 17);
    check_eq("t1_ypulses", y_cyc.size(), 1);
    check_eq("t1_ydelay", (y_cyc.size() > 0 ? y_cyc[0] : -1000) - first_acc(), 7);

    // T2: requester 1, two back-to-back matches
    serve(1, 16'hD750);
    check_eq("t2_id", resp_ids.size() > 0 ? resp_ids[0] : 9, 1);
    check_eq("t2_count", last_cnt, 2);
    check_eq("t2_ypulses", y_cyc.size(), 2);
    check_eq("t2_ygap", y_cyc.size() == 2 ? y_cyc[1] - y_cyc[0] : -1, 6);

    // T3: partial match then recovery
    serve(0, 16'hDEA0);
    check_eq("t3_count", last_cnt, 1);

    // T4: both requesters valid right after reset
    do_reset();
    clear_obs();
    req0_valid = 1; req0_data = 16'hD400;
    req1_valid = 1; req1_data = 16'hD750;
    for (int t = 0; t < 60 && (req0_valid || req1_valid); t++) begin
      cycle();
      if (acc0) req0_valid = 0;
      if (acc1) req1_valid = 0;
    end
    wait_resp();
    check_eq("t4_accepts", acc_cyc.size(), 2);
    check_eq("t4_spacing", acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1, 18);
    check_eq("t4_resps", resp_ids.size(), 2);
    check_eq("t4_order", resp_ids.size() == 2 ? {resp_ids[0][0], resp_ids[1][0]} : 2'b11, 2'b01);
    check_eq("t4_count1", last_cnt, 2);

    // T5: load a new pattern on the accept edge, then try loading mid-shift
    pat_load = 1; pat_in = 6'b101010;
    serve(0, 16'hAAAA);
`ifdef SEQ_DET_OVERLAP_EN
    check_eq("t5_count", last_cnt, 6);
`else
    check_eq("t5_count", last_cnt, 2);
`endif
    clear_obs();
    req0_valid = 1; req0_data = 16'hAAAA;
    cycle();
    req0_valid = 0;
    pat_load = 1; pat_in = 6'b111111;
    for (int t = 0; t < 5; t++) cycle();
    pat_load = 0;
    wait_resp();
`ifdef SEQ_DET_OVERLAP_EN
    check_eq("t5_ignored", last_cnt, 6);
`else
    check_eq("t5_ignored", last_cnt, 2);
`endif

    // T6: reset while bit 8 is on x_out
    req0_valid = 1; req0_data = 16'hD400;
    cycle();
    req0_valid = 0;
    for (int t = 0; t < 7; t++) cycle();
    begin
      int n0;
      n0 = n_resp;
      do_reset();
      for (int t = 0; t < 20; t++) cycle();
      check_eq("t6_no_resp", n_resp - n0, 0);
    end
    serve(0, 16'hAAAA);
    check_eq("t6_default_pat", last_cnt, 0);
    serve(0, 16'hD400);
    check_eq("t6_default_hit", last_cnt, 1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if (!req0_valid && $urandom_range(3) == 0) begin req0_valid = 1; req0_data = rand_word(); end
      if (!req1_valid && $urandom_range(3) == 0) begin req1_valid = 1; req1_data = rand_word(); end
      pat_load = ($urandom_range(15) == 0);
      pat_in   = ($urandom_range(1) == 1) ? PDEF : PW'($urandom);
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        cycle();
        if (acc0) req0_valid = 0;
        if (acc1) req1_valid = 0;
      end
    end
    req0_valid = 0;
    req1_valid = 0;
    pat_load   = 0;
    for (int t = 0; t < W + 4; t++) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
